clock_sequencer: RTL and testbench

CLOCK_SEQUENCER -- requirements
Module: clock_sequencer

---
 rtl/clock_sequencer.sv | 113 +++++++++++
 tb/tb_clock_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_sequencer.sv
// clock_sequencer: holds a stretched reset, then generates per-channel
// clock-enable pulses from programmable divisors. Channel 0 (CPU) supports
// run/halt control and single-period stepping.
module clock_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int CHANNELS     = 2,
    parameter int DIV_WIDTH    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          step,
    input  logic [CHANNELS*DIV_WIDTH-1:0] divisor,
    output logic                          sys_reset,
    output logic [CHANNELS-1:0]           enable,
    output logic                          halted,
    output logic [15:0]                   period_count
);

    localparam int HW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_HALT, S_STEP} state_t;

    state_t                               state_q, state_d;
    logic [HW-1:0]                        hold_q, hold_d;
    logic [CHANNELS-1:0][DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CHANNELS-1:0][DIV_WIDTH-1:0]   dl_q, dl_d;
    logic [15:0]                          period_count_q, period_count_d;
    logic                                 step_q, step_d;
    logic                                 counting;
    logic                                 hold_done;
    logic                                 step_edge;

    assign counting     = (state_q == S_RUN) || (state_q == S_STEP);
    assign hold_done    = (hold_q == HW'(RESET_CYCLES - 1));
    assign step_edge    = step && !step_q;
    assign sys_reset    = (state_q == S_HOLD);
    assign halted       = (state_q == S_HALT);
    assign period_count = period_count_q;

    // Enable pulse fires on the last count of each channel's latched period.
    always_comb begin
        enable = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            enable[i] = counting && (cnt_q[i] == dl_q[i] - DIV_WIDTH'(1));
        end
    end

    // Next-state logic; run has priority over step in HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD: if (hold_done) state_d = run ? S_RUN : S_HALT;
            S_RUN:  if (!run && enable[0]) state_d = S_HALT;
            S_HALT: begin
                if (run)            state_d = S_RUN;
                else if (step_edge) state_d = S_STEP;
            end
            S_STEP: if (enable[0]) state_d = run ? S_RUN : S_HALT;
            default: state_d = S_HOLD;
        endcase
    end

    // Datapath: hold counter, per-channel counters and divisor latches.
    // Divisors are latched on HOLD exit and at each wrap, so a change made
    // mid-period only takes effect on the following period. A zero divisor
    // is stored as 1 so the channel pulses every counting cycle.
    always_comb begin
        logic [DIV_WIDTH-1:0] div_i;
        hold_d         = hold_q;
        cnt_d          = cnt_q;
        dl_d           = dl_q;
        step_d         = step;
        period_count_d = period_count_q + {15'd0, enable[0]};
        if (state_q == S_HOLD) hold_d = hold_q + HW'(1);
        for (int i = 0; i < CHANNELS; i++) begin
            div_i = divisor[i*DIV_WIDTH +: DIV_WIDTH];
            if (div_i == '0) div_i = DIV_WIDTH'(1);
            if (state_q == S_HOLD && hold_done) begin
                dl_d[i] = div_i;
            end else if (counting) begin
                if (enable[i]) begin
                    cnt_d[i] = '0;
                    dl_d[i]  = div_i;
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_HOLD;
            hold_q         <= '0;
            step_q         <= 1'b0;
            period_count_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                dl_q[i]  <= DIV_WIDTH'(1);
            end
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            step_q         <= step_d;
            period_count_q <= period_count_d;
            cnt_q          <= cnt_d;
            dl_q           <= dl_d;
        end
    end

endmodule

// File: tb/tb_clock_sequencer.sv
// tb_clock_sequencer: directed and randomized stimulus for clock_sequencer,
// checked every cycle against a behavioural model of the sequencing rules.
module tb_clock_sequencer;

    localparam int RC = 16;
    localparam int CH = 2;
    localparam int DW = 8;

    localparam int M_HOLD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_STEP = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             run;
    logic             step;
    logic [CH*DW-1:0] divisor;
    logic             sys_reset;
    logic [CH-1:0]    enable;
    logic             halted;
    logic [15:0]      period_count;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: mode, cycles spent holding, per-channel phase and period.
    int m_mode = M_HOLD;
    int m_hold = 0;
    int m_cnt[CH];
    int m_dl[CH];
    int m_pc = 0;
    bit m_stepq = 1'b0;

    clock_sequencer #(.RESET_CYCLES(RC), .CHANNELS(CH), .DIV_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .divisor(divisor),
        .sys_reset(sys_reset), .enable(enable), .halted(halted),
        .period_count(period_count)
    );

    always #5 clock = ~clock;

    function automatic int divof(int c);
        int d;
        d = int'(divisor[c*DW +: DW]);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic [CH-1:0] m_enable();
        logic [CH-1:0] en;
        en = '0;
        for (int c = 0; c < CH; c++)
            en[c] = (m_mode == M_RUN || m_mode == M_STEP) && (m_cnt[c] == m_dl[c] - 1);
        return en;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("sys_reset", 32'(sys_reset), 32'(m_mode == M_HOLD));
        check("enable", 32'(enable), 32'(m_enable()));
        check("halted", 32'(halted), 32'(m_mode == M_HALT));
        check("period_count", 32'(period_count), 32'(m_pc));
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        logic [CH-1:0] en;
        bit cnting;
        en = m_enable();
        cnting = (m_mode == M_RUN || m_mode == M_STEP);
        if (reset) begin
            m_mode = M_HOLD; m_hold = 0; m_pc = 0; m_stepq = 1'b0;
            for (int c = 0; c < CH; c++) begin m_cnt[c] = 0; m_dl[c] = 1; end
        end else begin
            if (cnting)
                for (int c = 0; c < CH; c++) begin
                    if (en[c]) begin m_cnt[c] = 0; m_dl[c] = divof(c); end
                    else m_cnt[c] = m_cnt[c] + 1;
                end
            m_pc = (m_pc + int'(en[0])) % 65536;
            case (m_mode)
                M_HOLD: begin
                    m_hold++;
                    if (m_hold == RC) begin
                        m_mode = run ? M_RUN : M_HALT;
                        for (int c = 0; c < CH; c++) m_dl[c] = divof(c);
                    end
                end
                M_RUN:  if (!run && en[0]) m_mode = M_HALT;
                M_HALT: if (run) m_mode = M_RUN; else if (step && !m_stepq) m_mode = M_STEP;
                default: if (en[0]) m_mode = run ? M_RUN : M_HALT;
            endcase
            m_stepq = step;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        int n;
        int pulses;
        for (int c = 0; c < CH; c++) begin m_cnt[c] = 0; m_dl[c] = 1; end
        reset = 1'b1; run = 1'b1; step = 1'b0; divisor = {8'd1, 8'd4};

        // Reset for 3 cycles; DUT state is unknown before the first edge.
        @(posedge clock); model_edge(); #1;
        tick(); tick();
        check("rst_sys_reset", 32'(sys_reset), 32'd1);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_period_count", 32'(period_count), 32'd0);

        // Stretched reset lasts exactly RC cycles after release.
        reset = 1'b0; n = 0;
        while (sys_reset === 1'b1 && n < 40) begin tick(); n++; end
        check("hold_len", 32'(n), 32'(RC));

        // ch0=4, ch1=1: five ch0 periods in 20 RUN cycles.
        repeat (20) tick();
        check("pc_after_20", 32'(period_count), 32'd5);

        // Drop run one cycle after a pulse: one more pulse 3 cycles later.
        n = 0;
        while (enable[0] !== 1'b1 && n < 10) begin tick(); n++; end
        tick();
        run = 1'b0; n = 0;
        while (enable[0] !== 1'b1 && n < 10) begin tick(); n++; end
        check("drop_delay", 32'(n), 32'd3);
        tick();
        check("halt_after_drop", 32'(halted), 32'd1);
        check("halt_enable", 32'(enable), 32'd0);

        // Step held high: exactly one ch0 period, twice.
        step = 1'b1; pulses = 0;
        repeat (10) begin if (enable[0] === 1'b1) pulses++; tick(); end
        check("step1_pulses", 32'(pulses), 32'd1);
        check("step1_halted", 32'(halted), 32'd1);
        step = 1'b0; tick();
        step = 1'b1; pulses = 0;
        repeat (6) begin if (enable[0] === 1'b1) pulses++; tick(); end
        check("step2_pulses", 32'(pulses), 32'd1);
        step = 1'b0;

        // Divisor 4->2 mid-period: current period still completes at 4.
        run = 1'b1; tick(); tick();
        divisor = {8'd1, 8'd2}; pulses = 0;
        repeat (10) begin if (enable[0] === 1'b1) pulses++; tick(); end
        check("div_change_pulses", 32'(pulses), 32'd4);
        divisor = {8'd0, 8'd0};
        repeat (8) tick();

        // Randomized run/step/divisor/reset traffic.
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            run   = (m_mode == M_HOLD) ? 1'b1 : 1'($urandom_range(0, 1));
            step  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                divisor = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
            tick();
        end

        // Reset during STEP.
        reset = 1'b0; run = 1'b1; step = 1'b0; n = 0;
        while (sys_reset === 1'b1 && n < 40) begin tick(); n++; end
        divisor = {8'd3, 8'd5};
        run = 1'b0; n = 0;
        while (halted !== 1'b1 && n < 300) begin tick(); n++; end
        check("reach_halt", 32'(halted), 32'd1);
        step = 1'b1; tick(); tick(); tick();
        check("in_step", 32'(halted), 32'd0);
        reset = 1'b1; tick();
        check("rst_step_sys_reset", 32'(sys_reset), 32'd1);
        check("rst_step_enable", 32'(enable), 32'd0);
        check("rst_step_period_count", 32'(period_count), 32'd0);
        check("rst_step_halted", 32'(halted), 32'd0);
        reset = 1'b0; run = 1'b1; n = 0;
        while (sys_reset === 1'b1 && n < 40) begin tick(); n++; end
        check("hold_len_again", 32'(n), 32'(RC));
        repeat (6) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
